// File: rtl/escalonador_rr_pkg.sv
// escalonador_rr_pkg: slot/FSM encodings and process-layout defaults shared with the CPU display logic
package escalonador_rr_pkg;
    typedef enum logic [1:0] {SLOT_EMPTY, SLOT_READY, SLOT_BLOCKED, SLOT_DONE} slot_t;
    typedef enum logic [2:0] {ST_IDLE, ST_INIT, ST_RUN, ST_SELECT, ST_DISPATCH, ST_DONE} estado_t;
    localparam int DEF_MAX_PROC = 10;
    localparam int DEF_PROC_BASE = 300;
    localparam int DEF_PROC_REGION = 300;
    localparam logic [3:0] PID_IDLE = 4'd0;
    function automatic logic [3:0] proximo(input logic [3:0] id, input int max_id);
        return (int'(id) >= max_id) ? 4'd1 : id + 4'd1;
    endfunction
endpackage

// File: rtl/escalonador_rr_tabela_processos.sv
// tabela_processos: per-slot state and saved PC, written by id, read by scan id
module tabela_processos
    import escalonador_rr_pkg::*;
#(
    parameter int MAX_PROC = DEF_MAX_PROC,
    parameter int PC_W = 32,
    parameter int PROC_BASE = DEF_PROC_BASE,
    parameter int PROC_REGION = DEF_PROC_REGION
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            init,
    input  logic [3:0]      num,
    input  logic            wr_en,
    input  logic [3:0]      wr_id,
    input  logic [1:0]      wr_state,
    input  logic            wr_pc_en,
    input  logic [PC_W-1:0] wr_pc,
    input  logic            io_done,
    input  logic [3:0]      io_done_id,
    input  logic [3:0]      rd_id,
    output logic [1:0]      rd_state,
    output logic [PC_W-1:0] rd_pc,
    output logic [3:0]      n_blocked
);
    slot_t           estado   [1:MAX_PROC];
    logic [PC_W-1:0] pc_salvo [1:MAX_PROC];

    // a running-process write beats a same-cycle io_done on that slot
    always_ff @(posedge clock) begin
        for (int i = 1; i <= MAX_PROC; i++) begin
            if (!reset) begin
                estado[i]   <= SLOT_EMPTY;
                pc_salvo[i] <= '0;
            end else if (init) begin
                estado[i]   <= (i <= int'(num)) ? SLOT_READY : SLOT_EMPTY;
                pc_salvo[i] <= PC_W'(PROC_BASE + (i - 1) * PROC_REGION);
            end else begin
                if (wr_en && int'(wr_id) == i)
                    estado[i] <= slot_t'(wr_state);
                else if (io_done && int'(io_done_id) == i && estado[i] == SLOT_BLOCKED)
                    estado[i] <= SLOT_READY;
                if (wr_pc_en && int'(wr_id) == i)
                    pc_salvo[i] <= wr_pc;
            end
        end
    end

    always_comb begin
        rd_state  = SLOT_EMPTY;
        rd_pc     = '0;
        n_blocked = '0;
        for (int i = 1; i <= MAX_PROC; i++) begin
            if (int'(rd_id) == i) begin
                rd_state = estado[i];
                rd_pc    = pc_salvo[i];
            end
            n_blocked = n_blocked + 4'(estado[i] == SLOT_BLOCKED);
        end
    end
endmodule

// File: rtl/escalonador_rr.sv
// escalonador_rr: round-robin process scheduler with quantum counter and req/ack PC hand-off
// ESCALONADOR_STATS_EN adds trocas_total (completed switches) and bloqueios (blocked slots)
module escalonador_rr
    import escalonador_rr_pkg::*;
#(
    parameter int MAX_PROC = DEF_MAX_PROC,
    parameter int QUANTUM = 16,
    parameter int PROC_BASE = DEF_PROC_BASE,
    parameter int PROC_REGION = DEF_PROC_REGION,
    parameter int PC_W = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      num_proc,
    input  logic            instr_retire,
    input  logic            io_req,
    input  logic            io_done,
    input  logic [3:0]      io_done_id,
    input  logic            fim_processo,
    input  logic [PC_W-1:0] pc_atual,
    output logic            switch_req,
    input  logic            switch_ack,
    output logic [PC_W-1:0] next_pc,
    output logic [3:0]      processo_atual,
    output logic            all_done,
    output logic [7:0]      quantum_cnt
`ifdef ESCALONADOR_STATS_EN
    ,
    output logic [15:0]     trocas_total,
    output logic [3:0]      bloqueios
`endif
);
    estado_t         st;
    logic [3:0]      cur, sid, lap, n_proc, n_blocked;
    logic [1:0]      rd_state;
    logic [PC_W-1:0] rd_pc;
    logic            armed, in_run, expira, run_ev, any_blocked;

    assign in_run      = st == ST_RUN;
    assign expira      = instr_retire && quantum_cnt == 8'(QUANTUM - 1);
    assign run_ev      = in_run && (fim_processo || io_req || expira);
    assign any_blocked = n_blocked != 4'd0;

    tabela_processos #(
        .MAX_PROC(MAX_PROC), .PC_W(PC_W), .PROC_BASE(PROC_BASE), .PROC_REGION(PROC_REGION)
    ) u_tabela (
        .clock(clock),
        .reset(reset),
        .init(st == ST_INIT),
        .num(n_proc),
        .wr_en(run_ev),
        .wr_id(cur),
        .wr_state(fim_processo ? SLOT_DONE : io_req ? SLOT_BLOCKED : SLOT_READY),
        .wr_pc_en(run_ev && !fim_processo),
        .wr_pc(pc_atual),
        .io_done(io_done),
        .io_done_id(io_done_id),
        .rd_id(sid),
        .rd_state(rd_state),
        .rd_pc(rd_pc),
        .n_blocked(n_blocked)
    );

    // armed masks a switch_ack arriving in the cycle switch_req first shows
    always_ff @(posedge clock) begin
        if (!reset) begin
            st             <= ST_IDLE;
            cur            <= '0;
            sid            <= '0;
            lap            <= '0;
            n_proc         <= '0;
            armed          <= 1'b0;
            switch_req     <= 1'b0;
            next_pc        <= '0;
            processo_atual <= PID_IDLE;
            all_done       <= 1'b0;
            quantum_cnt    <= '0;
        end else begin
            if (in_run && instr_retire)
                quantum_cnt <= quantum_cnt + 8'd1;
            case (st)
                ST_IDLE, ST_DONE: if (start) begin
                    st       <= ST_INIT;
                    all_done <= 1'b0;
                    n_proc   <= (num_proc == 4'd0 || int'(num_proc) > MAX_PROC) ? 4'(MAX_PROC) : num_proc;
                end
                ST_INIT: begin
                    st             <= ST_DISPATCH;
                    cur            <= 4'd1;
                    armed          <= 1'b0;
                    switch_req     <= 1'b1;
                    next_pc        <= PC_W'(PROC_BASE);
                    processo_atual <= 4'd1;
                end
                ST_RUN: if (run_ev) begin
                    st  <= ST_SELECT;
                    sid <= proximo(cur, MAX_PROC);
                    lap <= '0;
                end
                ST_SELECT: if (rd_state == SLOT_READY) begin
                    st             <= ST_DISPATCH;
                    cur            <= sid;
                    armed          <= 1'b0;
                    switch_req     <= 1'b1;
                    next_pc        <= rd_pc;
                    processo_atual <= sid;
                end else begin
                    sid <= proximo(sid, MAX_PROC);
                    lap <= lap + 4'd1;
                    if (int'(lap) == MAX_PROC - 1) begin
                        lap            <= '0;
                        processo_atual <= PID_IDLE;
                        if (!any_blocked) begin
                            st       <= ST_DONE;
                            all_done <= 1'b1;
                        end
                    end
                end
                ST_DISPATCH: begin
                    armed <= 1'b1;
                    if (armed && switch_ack) begin
                        st          <= ST_RUN;
                        switch_req  <= 1'b0;
                        quantum_cnt <= '0;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

`ifdef ESCALONADOR_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset || ((st == ST_IDLE || st == ST_DONE) && start))
            trocas_total <= '0;
        else if (st == ST_DISPATCH && armed && switch_ack && trocas_total != 16'hFFFF)
            trocas_total <= trocas_total + 16'd1;
    end
    assign bloqueios = n_blocked;
`endif
endmodule

// File: doc/escalonador_rr.md
Name: escalonador_rr

Overview:
Round-robin process scheduler that sequences the CPU across up to MAX_PROC user processes, each in a fixed instruction-memory region. It counts retired instructions per quantum, keeps a process table (state plus saved PC), and on preemption, I/O block or process end picks the next runnable process. It then hands the CPU a new PC through a req/ack handshake. It sits beside the CPU datapath and drives the PC-load path and the process-number display.

Parameters:
MAX_PROC, 10, number of process-table slots (process ids 1..MAX_PROC)
QUANTUM, 16, retired instructions per time slice (legal range 1..255)
PROC_BASE, 300, start PC of process 1
PROC_REGION, 300, words per process region; process k starts at PROC_BASE+(k-1)*PROC_REGION
PC_W, 32, PC width

Ports:
clock  in  1  system clock; every flop on posedge
reset  in  1  synchronous, active-low
start  in  1  one-cycle pulse: load num_proc, initialise table, dispatch process 1
num_proc  in  4  process count, 1..MAX_PROC; 0 or >MAX_PROC is clamped to MAX_PROC
instr_retire  in  1  one pulse per executed instruction of the running process
io_req  in  1  running process blocks on I/O (IN instruction)
io_done  in  1  I/O complete pulse
io_done_id  in  4  process id released by io_done
fim_processo  in  1  running process has finished
pc_atual  in  PC_W  CPU PC, sampled when a context is saved
switch_req  out  1  new PC is valid; held until switch_ack
switch_ack  in  1  CPU has loaded next_pc
next_pc  out  PC_W  PC to load
processo_atual  out  4  running process id; 0 = none (BIOS/idle)
all_done  out  1  every loaded process finished
quantum_cnt  out  8  instructions retired in the current slice

Behaviour:
- Reset (reset==0 at posedge): state IDLE. All outputs 0. Table slots EMPTY. Reset has priority over every input, including mid-handshake.
- Slot states: EMPTY, READY, BLOCKED, DONE.
- FSM states:
  - IDLE: start -> INIT.
  - INIT: 1 cycle. Slots 1..num_proc become READY with saved PC = region base; other slots EMPTY. cur=1 -> DISPATCH.
  - RUN: instr_retire increments quantum_cnt. Events are sampled each cycle with priority fim_processo > io_req > quantum expiry:
    - fim_processo: slot DONE, no PC save -> SELECT.
    - io_req: save pc_atual, slot BLOCKED -> SELECT.
    - expiry (instr_retire while quantum_cnt==QUANTUM-1): save pc_atual, slot stays READY -> SELECT.
  - SELECT: scans one slot per cycle starting at cur+1 and wrapping MAX_PROC->1. The current slot is checked last.
    - First READY slot found -> DISPATCH.
    - Full lap with none READY but some BLOCKED: processo_atual=0; re-scan until io_done readies a slot.
    - No READY or BLOCKED slots -> DONE.
  - DISPATCH: switch_req=1, next_pc=saved PC, processo_atual=new id. On switch_ack: drop switch_req, clear quantum_cnt -> RUN. A switch_ack in the same cycle switch_req rises is ignored.
  - DONE: all_done=1, processo_atual=0. start -> INIT.
- io_done is accepted in any state. A BLOCKED slot io_done_id becomes READY. io_done for a non-BLOCKED or out-of-range id is ignored.
- If io_done and io_req hit the same slot in the same cycle, io_req wins (slot ends BLOCKED).
- instr_retire is ignored outside RUN.
- start is ignored outside IDLE/DONE.
- Saved PC is truncated to PC_W. quantum_cnt wraps only via clear.
- Latency: event to switch_req is at most MAX_PROC+2 cycles.

Optional Feature:
ESCALONADOR_STATS_EN:
- Defined: adds output trocas_total (16 bit), which counts completed switch_ack handshakes, saturates at 16'hFFFF and clears on reset or start. Also adds output bloqueios (4 bit), the current number of BLOCKED slots.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared package: slot-state encoding, FSM state encoding, PROC_BASE/PROC_REGION/MAX_PROC defaults, and the BIOS/idle process id 0. The package is shared with the CPU LED/display logic.
- One sub-module, tabela_processos: slot state and saved-PC storage with write/read by id. The FSM and quantum counter stay in the top.

Test Plan:
- QUANTUM=4, num_proc=3, start, ack each switch_req after 1 cycle, continuous instr_retire: next_pc sequence 300, 600, 900, then 304 (300+4, saved PC).
- During process 2, io_req at pc_atual=602: switch to process 3. io_done id 2 ten cycles later: order proceeds 3 -> 1 -> 2 with next_pc=602.
- num_proc=2; fim_processo on each process: all_done=1, processo_atual=0, switch_req=0. A new start restarts at next_pc=300.
- All loaded processes blocked: processo_atual=0, no switch_req. io_done id 1: switch_req with process 1's saved PC within MAX_PROC+2 cycles.
- switch_req pending with no ack for 20 cycles: next_pc stable, instr_retire ignored. reset low mid-handshake: next cycle all outputs 0, state IDLE.
- Same-cycle fim_processo and quantum expiry: slot DONE, no PC save. Same-cycle io_done and io_req on slot 1: slot 1 ends BLOCKED.
